// File: rtl/basic_axis_example_mem_pkg.sv
// rtl/basic_axis_example_mem_pkg.sv - shared types and constants for the AXI4 memory responder
package basic_axis_example_mem_pkg;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    // Geometry of the default build: 512-bit words, 1024 words deep
    localparam int DEFAULT_DATA_WIDTH = 512;
    localparam int DEFAULT_MEM_DEPTH  = 1024;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int INDEX_W            = $clog2(DEFAULT_MEM_DEPTH);

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/basic_axis_example_mem_sdp.sv
// rtl/basic_axis_example_mem_sdp.sv - simple dual-port byte-enable RAM, read-first on collision
module basic_axis_example_mem_sdp #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [DATA_W/8-1:0] wr_strb,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [DATA_W-1:0]   rd_data
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write; array has no reset so contents survive aresetn
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; samples the array before this edge's write lands (read-first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/basic_axis_example_axi_mem_slave.sv
// rtl/basic_axis_example_axi_mem_slave.sv - AXI4 burst memory responder; optional AXI_MEM_SLVERR_EN adds resp ports
module basic_axis_example_axi_mem_slave
    import basic_axis_example_mem_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
`ifdef AXI_MEM_SLVERR_EN
    output logic [1:0]                      s_axi_bresp,
    output logic [1:0]                      s_axi_rresp,
`endif
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,
    output logic                            wlast_err
);

    localparam int WORD_BYTES = C_S_AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(WORD_BYTES);
    localparam int IDX_W      = $clog2(C_MEM_DEPTH_WORDS);
    localparam int IDX_TOP    = BYTE_SHIFT + IDX_W;

    rd_state_t rd_state;
    wr_state_t wr_state;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [7:0]       rd_len, rd_beat, wr_len, wr_beat;
    logic             rd_err, wr_err;

    // Word index with upper bits dropped, i.e. modulo depth
    logic [IDX_W-1:0] ar_idx, aw_idx;
    assign ar_idx = s_axi_araddr[IDX_TOP-1:BYTE_SHIFT];
    assign aw_idx = s_axi_awaddr[IDX_TOP-1:BYTE_SHIFT];

    logic ar_oor, aw_oor;
`ifdef AXI_MEM_SLVERR_EN
    assign ar_oor = |s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP];
    assign aw_oor = |s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP];
    logic unused_addr;
    assign unused_addr = ^{s_axi_araddr[BYTE_SHIFT-1:0], s_axi_awaddr[BYTE_SHIFT-1:0]};
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{s_axi_araddr[BYTE_SHIFT-1:0], s_axi_awaddr[BYTE_SHIFT-1:0],
                           s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP],
                           s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:IDX_TOP], rd_err};
`endif

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = s_axi_rvalid  & s_axi_rready;
    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign b_hs  = s_axi_bvalid  & s_axi_bready;

    // RAM read is fetched one cycle ahead: on AR for beat 0, on each R handshake for the next beat.
    // Holding rd_en low during a stall keeps rdata stable.
    logic             ram_rd_en;
    logic [IDX_W-1:0] ram_rd_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] ram_rd_data;
    assign ram_rd_en  = ar_hs | (r_hs & ~s_axi_rlast);
    assign ram_rd_idx = (rd_state == RD_IDLE) ? ar_idx : rd_idx + 1'b1;

    logic ram_wr_en;
    assign ram_wr_en = w_hs & ~wr_err;

    basic_axis_example_mem_sdp #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .DEPTH  (C_MEM_DEPTH_WORDS),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (aclk),
        .rst_n   (aresetn),
        .wr_en   (ram_wr_en),
        .wr_idx  (wr_idx),
        .wr_strb (s_axi_wstrb),
        .wr_data (s_axi_wdata),
        .rd_en   (ram_rd_en),
        .rd_idx  (ram_rd_idx),
        .rd_data (ram_rd_data)
    );

`ifdef AXI_MEM_SLVERR_EN
    assign s_axi_rdata = rd_err ? '0 : ram_rd_data;
    assign s_axi_rresp = rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s_axi_bresp = wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
    assign s_axi_rdata = ram_rd_data;
`endif

    // Read FSM: accept one AR, then stream arlen+1 beats
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state      <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            rd_idx        <= '0;
            rd_len        <= '0;
            rd_beat       <= '0;
            rd_err        <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (ar_hs) begin
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        rd_idx        <= ar_idx;
                        rd_len        <= s_axi_arlen;
                        rd_beat       <= '0;
                        rd_err        <= ar_oor;
                        rd_state      <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (r_hs) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            rd_state      <= RD_IDLE;
                        end else begin
                            rd_idx      <= rd_idx + 1'b1;
                            rd_beat     <= rd_beat + 8'd1;
                            s_axi_rlast <= (rd_beat + 8'd1 == rd_len);
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write FSM: accept one AW, absorb awlen+1 beats by count, then issue B
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state      <= WR_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            wr_idx        <= '0;
            wr_len        <= '0;
            wr_beat       <= '0;
            wr_err        <= 1'b0;
            wlast_err     <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (aw_hs) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        wr_idx        <= aw_idx;
                        wr_len        <= s_axi_awlen;
                        wr_beat       <= '0;
                        wr_err        <= aw_oor;
                        wr_state      <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        // wlast must agree with the count; mismatch is flagged but the count wins
                        if (s_axi_wlast != (wr_beat == wr_len)) begin
                            wlast_err <= 1'b1;
                        end
                        if (wr_beat == wr_len) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            wr_state     <= WR_RESP;
                        end else begin
                            wr_idx  <= wr_idx + 1'b1;
                            wr_beat <= wr_beat + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        wr_state      <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: doc/basic_axis_example_axi_mem_slave.md
Name: basic_axis_example_axi_mem_slave

Overview:
- Synthesizable AXI4 memory responder: the slave end of the kernel's AXI4 master interface (AR/R read path, AW/W/B write path).
- Backs a single-port-per-direction word memory, so the read-master → AXIS → write-master kernel datapath runs closed-loop in simulation and on-chip self-test without external DDR.
- Read and write channels are independent and run concurrently.

Parameters:
- C_S_AXI_ADDR_WIDTH, 64: byte address width.
- C_S_AXI_DATA_WIDTH, 512: data width in bits; power of two, ≥32.
- C_MEM_DEPTH_WORDS, 1024: memory depth in data-width words; power of two.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write byte address.
- s_axi_awlen  in  8  write burst length minus 1.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read byte address.
- s_axi_arlen  in  8  read burst length minus 1.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
- s_axi_rlast  out  1  last read beat.
- wlast_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (aresetn low, asynchronous): all ready/valid outputs 0, rdata 0, rlast 0, wlast_err 0; both FSMs go to IDLE. Memory contents are not cleared.
- awready/arready rise on the first aclk edge after aresetn deasserts.
- Reset mid-burst: the burst is abandoned immediately and no response is issued; completed writes persist.
- Addressing:
  - word index = addr >> log2(C_S_AXI_DATA_WIDTH/8), modulo C_MEM_DEPTH_WORDS.
  - Low byte-offset bits are ignored (aligned INCR bursts only).
  - Upper address bits wrap.
  - The beat index increments per beat and wraps modulo depth.
- Read FSM:
  - RD_IDLE (arready=1) → on AR handshake at cycle T, latch index and arlen; → RD_BURST.
  - RD_BURST (arready=0): rvalid=1 from T+1 with mem[index].
  - Each R handshake presents the next beat on the following cycle, giving one beat per cycle at full rready.
  - rdata/rlast are held stable while rvalid & !rready.
  - rlast=1 on beat arlen. Handshake on the last beat → RD_IDLE, rvalid=0 next cycle.
  - arlen=0 gives a single beat with rlast=1.
- Write FSM:
  - WR_IDLE (awready=1) → on AW handshake latch index and awlen; → WR_DATA.
  - WR_DATA (wready=1): each W handshake writes bytes where wstrb=1 and keeps the others.
  - The beat counter alone defines burst end (beat awlen); → WR_RESP.
  - WR_RESP (bvalid=1) from the cycle after the last W handshake; on B handshake → WR_IDLE.
  - W beats arriving before the AW handshake wait (wready=0 in WR_IDLE).
- Protocol errors:
  - wlast=1 on a non-final beat, or wlast=0 on the final beat, sets wlast_err.
  - wlast_err stays set until reset; the burst still completes by count.
- Read/write collision: a read and a write to the same word in the same cycle returns the old data (read-first); later reads see the new data.
- Only one outstanding burst per direction.

Optional Feature:
- Macro: AXI_MEM_SLVERR_EN.
- When defined:
  - Adds outputs s_axi_bresp[1:0] and s_axi_rresp[1:0].
  - Any burst whose start word index ≥ C_MEM_DEPTH_WORDS (address out of range, before modulo) gets SLVERR (2'b10) on every R beat or on B.
  - Erroring writes are discarded and erroring reads return 0.
  - Otherwise the response is OKAY (2'b00).
- When undefined: no resp ports, addresses wrap as above.

Decomposition:
- Package basic_axis_example_mem_pkg holds:
  - rd_state_t {RD_IDLE, RD_BURST}.
  - wr_state_t {WR_IDLE, WR_DATA, WR_RESP}.
  - localparams for bytes-per-word and index width.
  - AXI_RESP_OKAY/AXI_RESP_SLVERR constants.
- Sub-module: basic_axis_example_mem_sdp, a simple dual-port byte-enable RAM with read-first collision behaviour. The FSMs stay in the top module.

Test Plan:
- Write awaddr=0x0, awlen=3, data beats 1,2,3,4, wstrb all-ones → bvalid the cycle after beat 4. Then read araddr=0x0, arlen=3 → rdata 1,2,3,4, rlast on beat 4, rvalid at T+1.
- Fill word 5 with all 0xFF, then write 0x00 with wstrb=0x1 → readback byte0=0x00, bytes 1..63=0xFF.
- Read arlen=7 with rready pattern 1,0,1,0… → 8 beats in order, rdata stable during stalls, rlast only on beat 8.
- Write awaddr=0x10000 (depth 1024, 64 B words) → readback at araddr=0x0 returns that data.
- With AXI_MEM_SLVERR_EN defined, the same write returns bresp=2'b10 and word 0 is unchanged.
- awlen=3 with wlast asserted on beat 2 → wlast_err=1 and stays set, bvalid only after beat 4. Then drop aresetn mid-R-burst → rvalid=0 immediately, arready=1 one cycle after release, wlast_err=0.
